// File: rtl/spi_seq_pkg.sv
// Shared types, command constants and helpers for the SPI sensor sequencer.
// Command words use {rd, addr[6:0], data[7:0]}.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    CFG0,
    CFG1,
    CFG2,
    WAIT_INT,
    RD_PL,
    RD_PH,
    RD_YL,
    RD_YH
  } seq_state_t;

  localparam logic [15:0] CFG0_CMD = 16'h0D02;
  localparam logic [15:0] CFG1_CMD = 16'h1053;
  localparam logic [15:0] CFG2_CMD = 16'h1150;

  localparam logic [6:0] PTCH_L = 7'h22;
  localparam logic [6:0] PTCH_H = 7'h23;
  localparam logic [6:0] YAW_L  = 7'h26;
  localparam logic [6:0] YAW_H  = 7'h27;

  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

  // States that own an SPI transaction (issue phase, then wait-for-done phase)
  function automatic logic is_cmd_state(input seq_state_t s);
    return (s != PWR_WAIT) && (s != WAIT_INT);
  endfunction

  function automatic logic [15:0] state_cmd(input seq_state_t s);
    logic [15:0] c;
    case (s)
      CFG0:    c = CFG0_CMD;
      CFG1:    c = CFG1_CMD;
      CFG2:    c = CFG2_CMD;
      RD_PL:   c = rd_cmd(PTCH_L);
      RD_PH:   c = rd_cmd(PTCH_H);
      RD_YL:   c = rd_cmd(YAW_L);
      RD_YH:   c = rd_cmd(YAW_H);
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_sensor_seq_if.sv
// Handshake between the sequencer (master side) and the 16-bit SPI master.
interface spi_sensor_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/spi_sensor_seq.sv
// Power-up configuration and interrupt-driven pitch/yaw readout of an inertial
// sensor through a 16-bit SPI master.
module spi_sensor_seq
  import spi_seq_pkg::*;
#(
  parameter int unsigned INIT_DLY = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             INT,
  spi_sensor_seq_if.master spi,
  output logic [15:0]      ptch,
  output logic [15:0]      yaw,
  output logic             vld
);

  localparam logic [15:0] DLY_LAST = 16'(INIT_DLY - 1);

  seq_state_t  state_reg;
  seq_state_t  state_next;
  logic        issued_reg;
  logic [15:0] dly_cnt_reg;
  logic [15:0] cmd_reg;
  logic [7:0]  pl_hold_reg;
  logic [7:0]  ph_hold_reg;
  logic [7:0]  yl_hold_reg;
  logic [15:0] ptch_reg;
  logic [15:0] yaw_reg;
  logic        vld_reg;
  logic        int_s;
  logic        wait_done;
  logic        unused_rd_hi;

  sync2 u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  // done only counts once this state's wrt has gone out
  assign wait_done    = issued_reg & spi.done;
  assign unused_rd_hi = &spi.rd_data[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= PWR_WAIT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PWR_WAIT: if (dly_cnt_reg == DLY_LAST) state_next = CFG0;
      CFG0:     if (wait_done) state_next = CFG1;
      CFG1:     if (wait_done) state_next = CFG2;
      CFG2:     if (wait_done) state_next = WAIT_INT;
      WAIT_INT: if (int_s) state_next = RD_PL;
      RD_PL:    if (wait_done) state_next = RD_PH;
      RD_PH:    if (wait_done) state_next = RD_YL;
      RD_YL:    if (wait_done) state_next = RD_YH;
      RD_YH:    if (wait_done) state_next = WAIT_INT;
      default:  state_next = PWR_WAIT;
    endcase
  end

  always_comb begin
    spi.wrt = is_cmd_state(state_reg) & ~issued_reg;
  end

  assign spi.cmd = cmd_reg;
  assign ptch    = ptch_reg;
  assign yaw     = yaw_reg;
  assign vld     = vld_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_reg  <= 1'b0;
      dly_cnt_reg <= 16'h0000;
      cmd_reg     <= 16'h0000;
    end else begin
      issued_reg  <= is_cmd_state(state_reg) && (state_next == state_reg);
      dly_cnt_reg <= (state_reg == PWR_WAIT) ? dly_cnt_reg + 16'd1 : 16'h0000;
      // Load the command on entry so it is stable from the wrt cycle onward
      if ((state_next != state_reg) && is_cmd_state(state_next))
        cmd_reg <= state_cmd(state_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pl_hold_reg <= 8'h00;
      ph_hold_reg <= 8'h00;
      yl_hold_reg <= 8'h00;
      ptch_reg    <= 16'h0000;
      yaw_reg     <= 16'h0000;
      vld_reg     <= 1'b0;
    end else begin
      vld_reg <= 1'b0;
      if (wait_done) begin
        case (state_reg)
          RD_PL: pl_hold_reg <= spi.rd_data[7:0];
          RD_PH: ph_hold_reg <= spi.rd_data[7:0];
          RD_YL: yl_hold_reg <= spi.rd_data[7:0];
          RD_YH: begin
            ptch_reg <= {ph_hold_reg, pl_hold_reg};
            yaw_reg  <= {spi.rd_data[7:0], yl_hold_reg};
            vld_reg  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_seq.sv
// Directed bench for spi_sensor_seq: behavioural SPI master model with fixed
// done latency, transaction log, and pitch/yaw atomicity monitor.
module tb_spi_sensor_seq;

  localparam int DLY = 8;
  localparam int LAT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_in = 1'b0;
  logic [15:0] ptch;
  logic [15:0] yaw;
  logic        vld;
  logic        model_done = 1'b0;
  logic        spur_done = 1'b0;
  logic [15:0] model_rd = 16'h0000;

  spi_sensor_seq_if spi ();
  assign spi.done    = model_done | spur_done;
  assign spi.rd_data = model_rd;

  spi_sensor_seq #(.INIT_DLY(DLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .INT   (int_in),
    .spi   (spi),
    .ptch  (ptch),
    .yaw   (yaw),
    .vld   (vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [15:0] cmd_log[$];
  logic [31:0] vld_log[$];
  logic [7:0]  rsp_q[$];
  int wrt_cyc_q[$];
  int done_cyc_q[$];
  int vld_cyc_q[$];
  int wrt_cnt = 0;
  int vld_cnt = 0;
  int countdown = 0;
  int overlap = 0;
  int nonatomic = 0;
  int vld_multi = 0;
  logic [15:0] prev_p = 16'h0000;
  logic [15:0] prev_y = 16'h0000;
  logic        prev_vld = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI master model plus output monitor, sampled 1 time unit after each edge
  always begin
    @(posedge clk);
    #1;
    model_done = 1'b0;
    if (!rst_n) begin
      countdown = 0;
    end else if (spi.wrt) begin
      if (countdown != 0) overlap++;
      cmd_log.push_back(spi.cmd);
      wrt_cyc_q.push_back(cyc);
      wrt_cnt++;
      $display("wrt %0d cmd=%h cyc=%0d", wrt_cnt, spi.cmd, cyc);
      countdown = LAT;
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        model_done = 1'b1;
        if (rsp_q.size() > 0) model_rd = {8'hEE, rsp_q.pop_front()};
        else                  model_rd = 16'hEE00;
        done_cyc_q.push_back(cyc);
      end
    end
    if (rst_n) begin
      if (vld) begin
        vld_cnt++;
        vld_log.push_back({ptch, yaw});
        vld_cyc_q.push_back(cyc);
        $display("vld ptch=%h yaw=%h cyc=%0d", ptch, yaw, cyc);
        if (prev_vld) vld_multi++;
      end else if ((ptch != prev_p) || (yaw != prev_y)) begin
        nonatomic++;
      end
    end
    prev_p   = ptch;
    prev_y   = yaw;
    prev_vld = vld;
  end

  task automatic wait_wrt(input int n, input string tag);
    for (int i = 0; i < 3000 && wrt_cnt < n; i++) @(negedge clk);
    check_eq(tag, 64'(wrt_cnt >= n), 64'd1);
  endtask

  task automatic wait_vld(input int n, input string tag);
    for (int i = 0; i < 3000 && vld_cnt < n; i++) @(negedge clk);
    check_eq(tag, 64'(vld_cnt >= n), 64'd1);
  endtask

  task automatic pulse_spur_done();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
  endtask

  int rel;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_wrt", spi.wrt, 0);
    check_eq("rst_cmd", spi.cmd, 0);
    check_eq("rst_ptch", ptch, 0);
    check_eq("rst_yaw", yaw, 0);
    check_eq("rst_vld", vld, 0);

    // Power-up with a stray done inside the delay
    rst_n = 1'b1;
    rel = cyc;
    @(negedge clk);
    pulse_spur_done();
    wait_wrt(1, "to_cfg0");
    check_eq("pwr_dly", wrt_cyc_q[0] - rel, DLY);
    check_eq("cfg0_cmd", cmd_log[0], 16'h0D02);
    wait_wrt(3, "to_cfg2");
    repeat (LAT + 5) @(negedge clk);
    check_eq("cfg1_cmd", cmd_log[1], 16'h1053);
    check_eq("cfg2_cmd", cmd_log[2], 16'h1150);
    check_eq("cfg1_gap", wrt_cyc_q[1] - done_cyc_q[0], 1);
    check_eq("cfg2_gap", wrt_cyc_q[2] - done_cyc_q[1], 1);

    repeat (60) @(negedge clk);
    pulse_spur_done();
    repeat (10) @(negedge clk);
    check_eq("idle_no_wrt", wrt_cnt, 3);
    check_eq("idle_no_vld", vld_cnt, 0);

    // First read; INT stays high so a second read follows immediately
    rsp_q = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h78, 8'h56, 8'h00, 8'h80};
    int_in = 1'b1;
    wait_vld(1, "to_vld1");
    check_eq("rd1_val", vld_log[0], 32'h1234ABCD);
    check_eq("rd_pl_cmd", cmd_log[3], 16'hA200);
    check_eq("rd_ph_cmd", cmd_log[4], 16'hA300);
    check_eq("rd_yl_cmd", cmd_log[5], 16'hA600);
    check_eq("rd_yh_cmd", cmd_log[6], 16'hA700);
    check_eq("rd_ph_gap", wrt_cyc_q[4] - done_cyc_q[3], 1);
    check_eq("vld1_lat", vld_cyc_q[0] - done_cyc_q[6], 1);

    // Second read: glitch INT during the RD_YL wait, then leave it low
    wait_wrt(10, "to_rd2_yl");
    check_eq("restart_gap", wrt_cyc_q[7] - done_cyc_q[6], 2);
    repeat (3) @(negedge clk);
    int_in = 1'b0;
    repeat (4) @(negedge clk);
    int_in = 1'b1;
    repeat (4) @(negedge clk);
    int_in = 1'b0;
    wait_vld(2, "to_vld2");
    check_eq("rd2_val", vld_log[1], 32'h56788000);
    check_eq("rd2_yh_cmd", cmd_log[10], 16'hA700);
    repeat (50) @(negedge clk);
    check_eq("no_restart", wrt_cnt, 11);
    pulse_spur_done();
    repeat (5) @(negedge clk);
    check_eq("spur_ptch", ptch, 16'h5678);
    check_eq("spur_yaw", yaw, 16'h8000);
    check_eq("spur_wrt", wrt_cnt, 11);
    check_eq("spur_vld", vld_cnt, 2);

    // Third read interrupted by reset during the RD_PH wait
    int_in = 1'b1;
    wait_wrt(13, "to_rd3_ph");
    check_eq("rd3_ph_cmd", cmd_log[12], 16'hA300);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_wrt", spi.wrt, 0);
    check_eq("arst_cmd", spi.cmd, 0);
    check_eq("arst_ptch", ptch, 0);
    check_eq("arst_yaw", yaw, 0);
    check_eq("arst_vld", vld, 0);
    int_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    wait_wrt(16, "to_recfg");
    check_eq("re_pwr_dly", wrt_cyc_q[13] - rel, DLY);
    check_eq("re_cfg0", cmd_log[13], 16'h0D02);
    check_eq("re_cfg1", cmd_log[14], 16'h1053);
    check_eq("re_cfg2", cmd_log[15], 16'h1150);
    repeat (LAT + 40) @(negedge clk);
    check_eq("re_idle", wrt_cnt, 16);

    check_eq("overlap", overlap, 0);
    check_eq("nonatomic", nonatomic, 0);
    check_eq("vld_width", vld_multi, 0);
    check_eq("vld_total", vld_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sensor_seq.md
Name: spi_sensor_seq

Overview:
- Transaction sequencer that sits directly upstream of the team's 16-bit SPI master and owns its wrt/cmd/done interface.
- After reset, waits a power-up delay, then issues a fixed sequence of three configuration writes to an inertial sensor.
- It then services the sensor's data-ready interrupt by reading four 8-bit registers.
- It presents atomically-updated 16-bit pitch and yaw values with a one-cycle valid strobe.

Parameters:
- INIT_DLY, 16'hFFFF, clk cycles spent in power-up wait before the first configuration write (1..65535).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- INT  input  1  sensor data-ready interrupt; asynchronous, active-high, level
- done  input  1  SPI master transaction-complete pulse (one clk)
- rd_data  input  16  SPI master received word; valid in the cycle done is high
- wrt  output  1  start-transaction pulse to the SPI master
- cmd  output  16  command word to the SPI master
- ptch  output  16  assembled pitch value, {high byte, low byte}
- yaw  output  16  assembled yaw value, {high byte, low byte}
- vld  output  1  one-cycle strobe: ptch/yaw updated this cycle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset values: wrt=0, cmd=16'h0000, ptch=16'h0000, yaw=16'h0000, vld=0, state=PWR_WAIT, delay counter=0, INT synchronizer=0, byte holding registers=0.
- Reset mid-transaction immediately returns to PWR_WAIT. The SPI master is reset by the same rst_n, so no cleanup is required.

INT handling:
- INT passes through a 2-flop synchronizer; only the synchronized INT_s is used.
- INT_s is sampled only in WAIT_INT. INT activity in any other state is ignored and not queued.
- If INT_s is still high on re-entry to WAIT_INT, a new read sequence starts on the next edge.

Command-state protocol:
- Every command state asserts wrt for exactly one clk, in its first cycle. cmd is registered and stable from that cycle until done.
- The state then waits for done. Any done received outside a wait phase is ignored.
- The next command state is entered on the edge after done, so its wrt comes 1 cycle after the prior done.

State machine:
- PWR_WAIT: 16-bit counter increments each cycle. When counter == INIT_DLY-1, go to CFG0.
- CFG0, cmd 16'h0D02 (INT enable) -> CFG1.
- CFG1, cmd 16'h1053 (accel config) -> CFG2.
- CFG2, cmd 16'h1150 (gyro config) -> WAIT_INT.
- WAIT_INT: if INT_s == 1, go to RD_PL.
- RD_PL, cmd 16'hA200: on done, pl_hold <= rd_data[7:0] -> RD_PH.
- RD_PH, cmd 16'hA300: on done, ph_hold <= rd_data[7:0] -> RD_YL.
- RD_YL, cmd 16'hA600: on done, yl_hold <= rd_data[7:0] -> RD_YH.
- RD_YH, cmd 16'hA700: on done, in the same edge:
  - ptch <= {ph_hold, pl_hold}
  - yaw <= {rd_data[7:0], yl_hold}
  - vld <= 1 for one cycle
  - -> WAIT_INT
- Read command format is {1'b1, addr[6:0], 8'h00}. Configuration writes are {1'b0, addr[6:0], data[7:0]}. Upper byte of rd_data is ignored.
- ptch and yaw change only on the RD_YH done edge, never partially. They hold their value otherwise.
- vld is high in exactly the first cycle in which the new values are visible.
- Exactly one SPI transaction is outstanding at any time; wrt never asserts while waiting for done.
- No timeout: a missing done stalls the FSM in its wait phase indefinitely.

Decomposition:
- Shared package spi_seq_pkg:
  - state enum
  - configuration command constants CFG0_CMD, CFG1_CMD, CFG2_CMD
  - register addresses PTCH_L, PTCH_H, YAW_L, YAW_H
  - read-command build function
- One sub-module is natural: sync2, the 2-flop INT synchronizer (reset to 0).
- The FSM, delay counter and holding registers remain in spi_sensor_seq.

Test Plan:
- Power-up: INIT_DLY=8, model SPI returns done 40 cycles after each wrt. Required response:
  - first wrt occurs 8 cycles after rst_n deasserts, with cmd=16'h0D02
  - then 16'h1053, then 16'h1150, each wrt exactly 1 cycle after the prior done
  - no further wrt while INT=0
- Read sequence: INT held high, model returns 0x34, 0x12, 0xCD, 0xAB. Required response:
  - cmds in order A200, A300, A600, A700
  - ptch=16'h1234 and yaw=16'hABCD appear in the same cycle with vld=1 for exactly one cycle
- Atomicity: prior ptch=16'h1234; a second sequence returns 0x78, 0x56, 0x00, 0x80. Required response:
  - ptch stays 16'h1234 through RD_PH/RD_YL/RD_YH waits
  - then ptch=16'h5678 and yaw=16'h8000 together with vld
- INT mid-sequence: INT pulses low-then-high during RD_YL. Required response:
  - no restart and no extra wrt
  - after vld, a new RD_PL wrt issues only if INT_s is high in WAIT_INT
- Spurious done: done pulsed during PWR_WAIT and WAIT_INT. Required response: no state change, no wrt, ptch/yaw/vld unchanged.
- Reset mid-transaction: assert rst_n low during the RD_PH wait. Required response:
  - all outputs 0 immediately (asynchronous)
  - after release, the full PWR_WAIT + CFG0..CFG2 sequence repeats
